constraint_sample_sequencer: RTL

Sequencer for the generated combinational constraint-check module (`generated_module`: five variable inputs, eight `constraint_N` outputs). On `start` it draws pseudo-random candidate assignments from an internal LFSR and drives them onto the checker's `var_*` inputs. It then reads back the constraint bits, emits candidates that satisfy all enabled constraints on a valid/ready stream, and counts tries and accepts. It stops when the accept target is reached, the try budget is exhausted, or `abort` is asserted. The checker is instantiated beside this block, not inside it.

---
 rtl/constraint_sample_sequencer_pkg.sv | 39 +++
 rtl/constraint_sample_sequencer_lfsr64.sv | 24 ++
 rtl/constraint_sample_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/constraint_sample_sequencer_pkg.sv
// Shared types and constants for the constraint sample sequencer: FSM states,
// LFSR feedback polynomial, candidate variable layout and the sample packing helper.
package constraint_sampler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    EVAL,
    EMIT,
    DONE
  } state_t;

  localparam logic [63:0] LFSR_POLY = 64'hD800_0000_0000_0000;

  localparam int VAR0_W = 13;
  localparam int VAR1_W = 13;
  localparam int VAR2_W = 14;
  localparam int VAR3_W = 14;
  localparam int VAR4_W = 8;

  localparam int VAR0_LSB = 0;
  localparam int VAR1_LSB = VAR0_LSB + VAR0_W;
  localparam int VAR2_LSB = VAR1_LSB + VAR1_W;
  localparam int VAR3_LSB = VAR2_LSB + VAR2_W;
  localparam int VAR4_LSB = VAR3_LSB + VAR3_W;

  localparam int SAMPLE_BITS = VAR4_LSB + VAR4_W;

  function automatic logic [SAMPLE_BITS-1:0] pack_sample(
    input logic [VAR0_W-1:0] v0,
    input logic [VAR1_W-1:0] v1,
    input logic [VAR2_W-1:0] v2,
    input logic [VAR3_W-1:0] v3,
    input logic [VAR4_W-1:0] v4
  );
    return {v4, v3, v2, v1, v0};
  endfunction

endpackage

// File: rtl/constraint_sample_sequencer_lfsr64.sv
// 64-bit right-shifting Galois LFSR that supplies candidate bits to the sequencer.
module lfsr64
  import constraint_sampler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        step,
  output logic [63:0] state
);

  // An all-zero state would lock the register, so a zero seed becomes 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= 64'h1;
    end else if (load) begin
      state <= (seed == 64'h0) ? 64'h1 : seed;
    end else if (step) begin
      state <= state[0] ? ((state >> 1) ^ LFSR_POLY) : (state >> 1);
    end
  end

endmodule

// File: rtl/constraint_sample_sequencer.sv
// Drives random candidates into an external combinational constraint checker and
// streams out the candidates that satisfy every enabled constraint.
module constraint_sample_sequencer
  import constraint_sampler_pkg::*;
#(
  parameter int NUM_CONS = 8,
  parameter int CNT_W    = 16,
  parameter int SAMPLE_W = 62
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [63:0]         seed,
  input  logic [CNT_W-1:0]    target_count,
  input  logic [CNT_W-1:0]    max_tries,
  input  logic [NUM_CONS-1:0] cons_mask,
  output logic [12:0]         var_0,
  output logic [12:0]         var_1,
  output logic [13:0]         var_2,
  output logic [13:0]         var_3,
  output logic [7:0]          var_4,
  input  logic [NUM_CONS-1:0] constraint_in,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [CNT_W-1:0]    tries_count,
  output logic [CNT_W-1:0]    accept_count
);

  state_t              state_q;
  logic [CNT_W-1:0]    target_q;
  logic [CNT_W-1:0]    max_q;
  logic [NUM_CONS-1:0] mask_q;

  logic [63:0]         lfsr_state;
  logic                lfsr_load;
  logic                lfsr_step;
  logic                lfsr_unused;

  logic                pass;
  logic                budget_spent;
  logic                handshake;
  logic [CNT_W-1:0]    accept_next;

  assign lfsr_load    = (state_q == IDLE) && start;
  assign lfsr_step    = (state_q == GEN) && !abort;
  assign lfsr_unused  = ^lfsr_state[63:SAMPLE_BITS];

  assign pass         = &(constraint_in | ~mask_q);
  assign budget_spent = (max_q != '0) && (tries_count == max_q);
  assign handshake    = sample_valid && sample_ready;
  assign accept_next  = accept_count + 1'b1;

  lfsr64 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  // Abort beats every other transition and leaves the counters readable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      target_q     <= '0;
      max_q        <= '0;
      mask_q       <= '0;
      var_0        <= '0;
      var_1        <= '0;
      var_2        <= '0;
      var_3        <= '0;
      var_4        <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      tries_count  <= '0;
      accept_count <= '0;
    end else if (abort && (state_q != IDLE)) begin
      state_q      <= IDLE;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            tries_count  <= '0;
            accept_count <= '0;
            timeout      <= 1'b0;
            target_q     <= target_count;
            max_q        <= max_tries;
            mask_q       <= cons_mask;
            busy         <= 1'b1;
            if (target_count == '0) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              state_q <= GEN;
            end
          end
        end

        GEN: begin
          var_0 <= lfsr_state[VAR0_LSB +: VAR0_W];
          var_1 <= lfsr_state[VAR1_LSB +: VAR1_W];
          var_2 <= lfsr_state[VAR2_LSB +: VAR2_W];
          var_3 <= lfsr_state[VAR3_LSB +: VAR3_W];
          var_4 <= lfsr_state[VAR4_LSB +: VAR4_W];
          if (tries_count != '1) begin
            tries_count <= tries_count + 1'b1;
          end
          state_q <= EVAL;
        end

        EVAL: begin
          if (pass) begin
            sample_data  <= pack_sample(var_0, var_1, var_2, var_3, var_4);
            sample_valid <= 1'b1;
            state_q      <= EMIT;
          end else if (budget_spent) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= GEN;
          end
        end

        // Reaching the target wins over a budget that ran out on the same try.
        EMIT: begin
          if (handshake) begin
            sample_valid <= 1'b0;
            accept_count <= accept_next;
            if (accept_next == target_q) begin
              done    <= 1'b1;
              state_q <= DONE;
            end else if (budget_spent) begin
              timeout <= 1'b1;
              done    <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= GEN;
            end
          end
        end

        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
